// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store sequencer in front of an 8-bit synchronous data RAM.
// Accepts byte or 16-bit word requests over a valid/ready handshake. Each word
// request becomes two byte accesses. The block drives the RAM's data_w/addr/din,
// captures dout, and returns one rsp_valid pulse per request.
//
// Optional build macro: DATA_MEM_CTRL_SIGN_EXT_EN
//   defined   -> byte loads sign-extend into rsp_rdata[15:8]
//   undefined -> byte loads zero-extend into rsp_rdata[15:8]
//
// Ports:
//   clk_in, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_we, req_word      1 = store / 1 = 16-bit access
//   req_addr, req_wdata   byte address, store data (a byte store uses [7:0])
//   rsp_valid, rsp_rdata  one-cycle completion pulse, load data
//   mem_we, mem_addr      RAM data_w, RAM addr
//   mem_din, mem_dout     RAM din, RAM dout (valid the cycle after a read edge)
module data_mem_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    CAP    = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e              state_q;
  logic                we_q;
  logic                word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [7:0]          byte0_q;   // first byte read back during a word load

  logic [7:0]          first_byte_c;
  logic [7:0]          second_byte_c;
  logic [7:0]          ext_hi_c;
  logic [15:0]         load_data_c;

  assign req_ready = (state_q == IDLE);

  // A byte store always writes req_wdata[7:0]. A word access writes its first byte
  // according to the byte order.
  assign first_byte_c  = (req_word && BIG_ENDIAN) ? req_wdata[15:8] : req_wdata[7:0];
  assign second_byte_c = BIG_ENDIAN ? wdata_q[7:0] : wdata_q[15:8];

`ifdef DATA_MEM_CTRL_SIGN_EXT_EN
  assign ext_hi_c = {8{mem_dout[7]}};
`else
  assign ext_hi_c = 8'h00;
`endif

  // Final load data, assembled while the last byte is on mem_dout (CAP).
  always_comb begin
    load_data_c = {ext_hi_c, mem_dout};
    if (word_q) begin
      load_data_c = BIG_ENDIAN ? {byte0_q, mem_dout} : {mem_dout, byte0_q};
    end
  end

  // Sequencer FSM and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      word_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byte0_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            word_q   <= req_word;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            mem_addr <= req_addr;
            mem_we   <= req_we;
            mem_din  <= first_byte_c;
            state_q  <= ACC_LO;
          end
        end
        ACC_LO: begin
          if (word_q) begin
            // The address wraps naturally at the ADDR_W boundary.
            mem_addr <= addr_q + ADDR_W'(1);
            mem_din  <= second_byte_c;
            state_q  <= ACC_HI;
          end else begin
            mem_we <= 1'b0;
            if (we_q) begin
              rsp_valid <= 1'b1;
              state_q   <= RESP;
            end else begin
              state_q   <= CAP;
            end
          end
        end
        ACC_HI: begin
          mem_we <= 1'b0;
          if (we_q) begin
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end else begin
            byte0_q <= mem_dout;
            state_q <= CAP;
          end
        end
        CAP: begin
          rsp_rdata <= load_data_c;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          mem_we    <= 1'b0;
          rsp_valid <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule
